// File: rtl/clk_div_ctrl.sv
// Run-time clock divider controller: glitch-free registered divided clock with
// boundary-aligned ratio changes and enable/disable sequencing.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | divided clock parked low, cnt held at 0, requests applied at once
//  RUN   | cnt sweeps 0..div_cur-1; changes and stop applied at the boundary
module clk_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_req,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_ack,
    output logic             o_err,
    output logic             o_busy,
    output logic             o_clk_div,
    output logic             o_tick_rise,
    output logic             o_tick_fall
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    state_t           state, state_nx;
    logic [CNT_W-1:0] div_cur, div_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] half_nx;
    logic             req_take, div_ok, boundary;
    logic             ack_nx, err_nx, busy_nx, clk_nx, rise_nx, fall_nx;

    // A request seen during the ack cycle is the one just serviced.
    assign req_take = i_req && !o_ack;
    assign div_ok   = (i_div >= TWO);
    assign boundary = (state == RUN) && (cnt == (div_cur - ONE));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        div_nx   = div_cur;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;

        if (req_take && !div_ok) begin
            ack_nx = 1'b1;
            err_nx = 1'b1;
        end

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (req_take && div_ok) begin
                    div_nx = i_div;
                    ack_nx = 1'b1;
                end
                if (i_en) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (boundary) begin
                    cnt_nx = '0;
                    if (req_take && div_ok) begin
                        div_nx = i_div;
                        ack_nx = 1'b1;
                    end
                    if (!i_en) begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Outputs are derived from next-state values so they register cleanly.
        half_nx = div_nx >> 1;
        busy_nx = (state_nx == RUN);
        clk_nx  = busy_nx && (cnt_nx < half_nx);
        rise_nx = busy_nx && (cnt_nx == '0);
        fall_nx = busy_nx && (cnt_nx == half_nx);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            div_cur     <= DIV_RST;
            o_ack       <= 1'b0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_clk_div   <= 1'b0;
            o_tick_rise <= 1'b0;
            o_tick_fall <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            div_cur     <= div_nx;
            o_ack       <= ack_nx;
            o_err       <= err_nx;
            o_busy      <= busy_nx;
            o_clk_div   <= clk_nx;
            o_tick_rise <= rise_nx;
            o_tick_fall <= fall_nx;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed-vector bench for clk_div_ctrl: each step queues the hand-computed
// output word for the following cycle; a monitor pops and compares each cycle.
module tb_clk_div_ctrl;

    // Output word layout: {busy, clk_div, tick_rise, tick_fall, ack, err}
    localparam logic [5:0] V_I = 6'b000000;
    localparam logic [5:0] V_R = 6'b111000;
    localparam logic [5:0] V_H = 6'b110000;
    localparam logic [5:0] V_F = 6'b100100;
    localparam logic [5:0] V_L = 6'b100000;
    localparam logic [5:0] V_A = 6'b000010;
    localparam logic [5:0] V_E = 6'b000011;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       req;
    logic [7:0] div;
    logic       ack, err, busy, clk_div, tick_rise, tick_fall;

    logic [5:0] exp_q[$];
    logic [5:0] exp_v;
    logic [5:0] act_v;
    int         n_vec  = 0;
    int         n_err  = 0;
    int         n_step = 0;

    clk_div_ctrl #(.CNT_W(8), .DIV_DEFAULT(2)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_req      (req),
        .i_div      (div),
        .o_ack      (ack),
        .o_err      (err),
        .o_busy     (busy),
        .o_clk_div  (clk_div),
        .o_tick_rise(tick_rise),
        .o_tick_fall(tick_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {busy, clk_div, tick_rise, tick_fall, ack, err};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL vec%0d busy/clk/rise/fall/ack/err got %b expected %b",
                         n_vec, act_v, exp_v);
            end
        end
    end

    task automatic step(input logic s_en, input logic s_req, input logic [7:0] s_div,
                        input logic [5:0] s_exp);
        en  = s_en;
        req = s_req;
        div = s_div;
        @(posedge clk);
        exp_q.push_back(s_exp);
        n_step++;
        #2;
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if ({busy, clk_div, tick_rise, tick_fall, ack, err} !== 6'b0) begin
            n_err++;
            $display("FAIL %s outputs got %b expected 000000", name,
                     {busy, clk_div, tick_rise, tick_fall, ack, err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d steps", n_step);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 1'b0;
        div   = 8'd0;
        #3;
        check_zero("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Default divisor 2 straight out of reset
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, V_R);
            step(1, 0, 0, V_F);
        end

        // Change to N=4 at the boundary
        step(1, 1, 8'd4, V_R | V_A);
        step(1, 0, 0, V_H);
        step(1, 0, 0, V_F);
        step(1, 0, 0, V_L);
        step(1, 0, 0, V_R);

        // Invalid divisor: immediate ack+err; req still high in ack cycle is ignored
        step(1, 1, 8'd1, V_H | V_E);
        step(1, 1, 8'd1, V_F);
        step(1, 0, 0, V_L);
        step(1, 0, 0, V_R);
        step(1, 0, 0, V_H);

        // Request N=5 raised at cnt=1, acked with the first high cycle
        step(1, 1, 8'd5, V_F);
        step(1, 1, 8'd5, V_L);
        step(1, 1, 8'd5, V_R | V_A);
        step(1, 0, 0, V_H);
        step(1, 0, 0, V_F);
        step(1, 0, 0, V_L);
        step(1, 0, 0, V_L);
        step(1, 0, 0, V_R);
        step(1, 0, 0, V_H);
        step(1, 0, 0, V_F);
        step(1, 0, 0, V_L);
        step(1, 0, 0, V_L);

        // N=6, disable at cnt=0: period completes, then request+disable together
        step(1, 1, 8'd6, V_R | V_A);
        step(0, 0, 0, V_H);
        step(0, 0, 0, V_H);
        step(0, 0, 0, V_F);
        step(0, 0, 0, V_L);
        step(0, 0, 0, V_L);
        step(0, 1, 8'd7, V_A);
        step(0, 0, 0, V_I);

        // Valid request in IDLE: one-cycle ack, stays idle
        step(0, 1, 8'd9, V_A);
        step(0, 0, 0, V_I);
        step(0, 0, 0, V_I);

        // Enable and request N=3 together
        step(1, 1, 8'd3, V_R | V_A);
        step(1, 0, 0, V_F);
        step(1, 0, 0, V_L);
        step(1, 0, 0, V_R);
        step(1, 0, 0, V_F);
        step(1, 0, 0, V_L);

        // N=8, reset while divided clock is high
        step(1, 1, 8'd8, V_R | V_A);
        step(1, 0, 0, V_H);
        step(1, 0, 0, V_H);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1 check_zero("reset_hold");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Back to default period 2
        step(1, 0, 0, V_R);
        step(1, 0, 0, V_F);
        step(1, 0, 0, V_R);
        step(1, 0, 0, V_F);

        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain pending %0d expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
